// File: rtl/vga_pkg.sv
// Shared timing constants, timing struct and width helpers for the VGA timing generator.
package vga_pkg;

    // Default 640x480@60 horizontal timing, in pixels.
    localparam int unsigned VGA_H_ACTIVE = 640;
    localparam int unsigned VGA_H_FRONT  = 16;
    localparam int unsigned VGA_H_SYNC   = 96;
    localparam int unsigned VGA_H_BACK   = 48;

    // Default 640x480@60 vertical timing, in lines.
    localparam int unsigned VGA_V_ACTIVE = 480;
    localparam int unsigned VGA_V_FRONT  = 10;
    localparam int unsigned VGA_V_SYNC   = 2;
    localparam int unsigned VGA_V_BACK   = 33;

    localparam int unsigned TIMING_FIELD_W = 16;

    // One axis worth of timing: visible region followed by front porch, sync, back porch.
    typedef struct packed {
        logic [TIMING_FIELD_W-1:0] active;
        logic [TIMING_FIELD_W-1:0] front;
        logic [TIMING_FIELD_W-1:0] sync;
        logic [TIMING_FIELD_W-1:0] back;
    } vga_timing_t;

    localparam vga_timing_t VGA_H_TIMING_DEFAULT = '{
        active: TIMING_FIELD_W'(VGA_H_ACTIVE),
        front:  TIMING_FIELD_W'(VGA_H_FRONT),
        sync:   TIMING_FIELD_W'(VGA_H_SYNC),
        back:   TIMING_FIELD_W'(VGA_H_BACK)
    };

    localparam vga_timing_t VGA_V_TIMING_DEFAULT = '{
        active: TIMING_FIELD_W'(VGA_V_ACTIVE),
        front:  TIMING_FIELD_W'(VGA_V_FRONT),
        sync:   TIMING_FIELD_W'(VGA_V_SYNC),
        back:   TIMING_FIELD_W'(VGA_V_BACK)
    };

    // Pack four scalar timing values into a timing struct.
    function automatic vga_timing_t make_timing(input int unsigned active,
                                                input int unsigned front,
                                                input int unsigned sync,
                                                input int unsigned back);
        vga_timing_t t;
        t.active = TIMING_FIELD_W'(active);
        t.front  = TIMING_FIELD_W'(front);
        t.sync   = TIMING_FIELD_W'(sync);
        t.back   = TIMING_FIELD_W'(back);
        return t;
    endfunction

    // Total period of one axis.
    function automatic int unsigned timing_total(input vga_timing_t t);
        return int'(t.active) + int'(t.front) + int'(t.sync) + int'(t.back);
    endfunction

    // First position of the sync window (inclusive).
    function automatic int unsigned sync_start(input vga_timing_t t);
        return int'(t.active) + int'(t.front);
    endfunction

    // First position after the sync window.
    function automatic int unsigned sync_end(input vga_timing_t t);
        return int'(t.active) + int'(t.front) + int'(t.sync);
    endfunction

    // Counter width able to hold 0..total-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned total);
        return (total > 1) ? $clog2(total) : 1;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Bundle of the timing generator's pixel-enable input and its registered timing outputs.
interface vga_timing_gen_if #(
    parameter int unsigned XW  = 10,
    parameter int unsigned YW  = 9,
    parameter int unsigned CXW = 10,
    parameter int unsigned CYW = 9,
    parameter int unsigned FCW = 8
);
    logic           i_pix_en;
    logic           o_draw_active;
    logic [XW-1:0]  o_active_x;
    logic [YW-1:0]  o_active_y;
    logic [CXW-1:0] o_cell_x;
    logic [CYW-1:0] o_cell_y;
    logic           o_h_sync;
    logic           o_v_sync;
    logic           o_line_start;
    logic           o_frame_start;
    logic           o_vblank;
    logic [FCW-1:0] o_frame_cnt;

    // Timing source side.
    modport master (
        input  i_pix_en,
        output o_draw_active, o_active_x, o_active_y, o_cell_x, o_cell_y,
        output o_h_sync, o_v_sync, o_line_start, o_frame_start, o_vblank, o_frame_cnt
    );

    // Pixel pipeline / display side.
    modport slave (
        output i_pix_en,
        input  o_draw_active, o_active_x, o_active_y, o_cell_x, o_cell_y,
        input  o_h_sync, o_v_sync, o_line_start, o_frame_start, o_vblank, o_frame_cnt
    );
endinterface

// File: rtl/vga_axis_counter.sv
// Single-axis position counter wrapping at TOTAL-1 by explicit compare.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter  int unsigned TOTAL = 800,
    localparam int unsigned W     = cnt_width(TOTAL)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_en,
    input  logic         i_step,
    output logic [W-1:0] o_cnt,
    output logic         o_wrap
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic         at_last;

    assign at_last = (cnt_q == W'(TOTAL - 1));

    // Combinational: a step requested while sitting on the last position, used to chain axes.
    assign o_wrap = i_step && at_last;
    assign o_cnt  = cnt_q;

    // Next count: hold unless enabled and stepped, wrap explicitly at the last position.
    always_comb begin
        cnt_d = cnt_q;
        if (i_en && i_step) begin
            cnt_d = at_last ? '0 : cnt_q + W'(1);
        end
    end

    // Position register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: x/y counters plus one-cycle-latency registered decode.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter  int unsigned H_ACTIVE    = VGA_H_ACTIVE,
    parameter  int unsigned H_FRONT     = VGA_H_FRONT,
    parameter  int unsigned H_SYNC      = VGA_H_SYNC,
    parameter  int unsigned H_BACK      = VGA_H_BACK,
    parameter  int unsigned V_ACTIVE    = VGA_V_ACTIVE,
    parameter  int unsigned V_FRONT     = VGA_V_FRONT,
    parameter  int unsigned V_SYNC      = VGA_V_SYNC,
    parameter  int unsigned V_BACK      = VGA_V_BACK,
    parameter  bit          H_SYNC_POL  = 1'b0,
    parameter  bit          V_SYNC_POL  = 1'b0,
    parameter  int unsigned SCALE_LOG2  = 0,
    parameter  int unsigned FRAME_CNT_W = 8,
    localparam int unsigned XW          = $clog2(H_ACTIVE),
    localparam int unsigned YW          = $clog2(V_ACTIVE),
    localparam int unsigned CXW         = XW - SCALE_LOG2,
    localparam int unsigned CYW         = YW - SCALE_LOG2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_pix_en,
    output logic                   o_draw_active,
    output logic [XW-1:0]          o_active_x,
    output logic [YW-1:0]          o_active_y,
    output logic [CXW-1:0]         o_cell_x,
    output logic [CYW-1:0]         o_cell_y,
    output logic                   o_h_sync,
    output logic                   o_v_sync,
    output logic                   o_line_start,
    output logic                   o_frame_start,
    output logic                   o_vblank,
    output logic [FRAME_CNT_W-1:0] o_frame_cnt
);

    localparam vga_timing_t H_T     = make_timing(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
    localparam vga_timing_t V_T     = make_timing(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);
    localparam int unsigned H_TOTAL = timing_total(H_T);
    localparam int unsigned V_TOTAL = timing_total(V_T);
    localparam int unsigned XCW     = cnt_width(H_TOTAL);
    localparam int unsigned YCW     = cnt_width(V_TOTAL);

    // Elaboration-time parameter legality.
    if (H_ACTIVE == 0 || H_FRONT == 0 || H_SYNC == 0 || H_BACK == 0 ||
        V_ACTIVE == 0 || V_FRONT == 0 || V_SYNC == 0 || V_BACK == 0) begin : g_bad_timing
        $error("vga_timing_gen: timing parameters must all be non-zero");
    end
    if (SCALE_LOG2 >= YW || SCALE_LOG2 >= XW) begin : g_bad_scale
        $error("vga_timing_gen: SCALE_LOG2 must be smaller than the coordinate widths");
    end

    logic [XCW-1:0] x_cnt;
    logic [YCW-1:0] y_cnt;
    logic           x_wrap;
    logic           y_wrap;

    // Horizontal counter steps on every enabled pixel.
    vga_axis_counter #(.TOTAL(H_TOTAL)) u_x_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_en   (i_pix_en),
        .i_step (1'b1),
        .o_cnt  (x_cnt),
        .o_wrap (x_wrap)
    );

    // Vertical counter steps when the line ends.
    vga_axis_counter #(.TOTAL(V_TOTAL)) u_y_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_en   (i_pix_en),
        .i_step (x_wrap),
        .o_cnt  (y_cnt),
        .o_wrap (y_wrap)
    );

    logic                   h_act;
    logic                   v_act;
    logic                   h_sync_win;
    logic                   v_sync_win;

    logic                   draw_active_q, draw_active_d;
    logic [XW-1:0]          active_x_q,    active_x_d;
    logic [YW-1:0]          active_y_q,    active_y_d;
    logic [CXW-1:0]         cell_x_q,      cell_x_d;
    logic [CYW-1:0]         cell_y_q,      cell_y_d;
    logic                   h_sync_q,      h_sync_d;
    logic                   v_sync_q,      v_sync_d;
    logic                   line_start_q,  line_start_d;
    logic                   frame_start_q, frame_start_d;
    logic                   vblank_q,      vblank_d;
    logic [FRAME_CNT_W-1:0] frame_cnt_q,   frame_cnt_d;

    // Region decode of the current (pre-advance) position.
    always_comb begin
        h_act      = (x_cnt < XCW'(H_ACTIVE));
        v_act      = (y_cnt < YCW'(V_ACTIVE));
        h_sync_win = (x_cnt >= XCW'(sync_start(H_T))) && (x_cnt < XCW'(sync_end(H_T)));
        v_sync_win = (y_cnt >= YCW'(sync_start(V_T))) && (y_cnt < YCW'(sync_end(V_T)));
    end

    // Output next-state: levels hold without a pixel enable, pulses always self-clear.
    always_comb begin
        draw_active_d = draw_active_q;
        active_x_d    = active_x_q;
        active_y_d    = active_y_q;
        cell_x_d      = cell_x_q;
        cell_y_d      = cell_y_q;
        h_sync_d      = h_sync_q;
        v_sync_d      = v_sync_q;
        vblank_d      = vblank_q;
        frame_cnt_d   = frame_cnt_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        if (i_pix_en) begin
            draw_active_d = h_act && v_act;
            active_x_d    = (h_act && v_act) ? XW'(x_cnt) : '0;
            active_y_d    = (h_act && v_act) ? YW'(y_cnt) : '0;
            cell_x_d      = CXW'(active_x_d >> SCALE_LOG2);
            cell_y_d      = CYW'(active_y_d >> SCALE_LOG2);
            h_sync_d      = h_sync_win ? H_SYNC_POL : ~H_SYNC_POL;
            v_sync_d      = v_sync_win ? V_SYNC_POL : ~V_SYNC_POL;
            vblank_d      = !v_act;
            line_start_d  = (x_cnt == '0);
            frame_start_d = (x_cnt == '0) && (y_cnt == '0);
            if (y_wrap) begin
                frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
            end
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            draw_active_q <= 1'b0;
            active_x_q    <= '0;
            active_y_q    <= '0;
            cell_x_q      <= '0;
            cell_y_q      <= '0;
            h_sync_q      <= ~H_SYNC_POL;
            v_sync_q      <= ~V_SYNC_POL;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            vblank_q      <= 1'b0;
            frame_cnt_q   <= '0;
        end else begin
            draw_active_q <= draw_active_d;
            active_x_q    <= active_x_d;
            active_y_q    <= active_y_d;
            cell_x_q      <= cell_x_d;
            cell_y_q      <= cell_y_d;
            h_sync_q      <= h_sync_d;
            v_sync_q      <= v_sync_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            vblank_q      <= vblank_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    assign o_draw_active = draw_active_q;
    assign o_active_x    = active_x_q;
    assign o_active_y    = active_y_q;
    assign o_cell_x      = cell_x_q;
    assign o_cell_y      = cell_y_q;
    assign o_h_sync      = h_sync_q;
    assign o_v_sync      = v_sync_q;
    assign o_line_start  = line_start_q;
    assign o_frame_start = frame_start_q;
    assign o_vblank      = vblank_q;
    assign o_frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a small 8/2/2/2 x 4/1/1/1 raster.
module tb_vga_timing_gen;

    localparam int unsigned HA  = 8;
    localparam int unsigned HF  = 2;
    localparam int unsigned HS  = 2;
    localparam int unsigned HB  = 2;
    localparam int unsigned VA  = 4;
    localparam int unsigned VF  = 1;
    localparam int unsigned VS  = 1;
    localparam int unsigned VB  = 1;
    localparam int unsigned HT  = 14;
    localparam int unsigned VT  = 7;
    localparam int unsigned XW  = 3;
    localparam int unsigned YW  = 2;
    localparam int unsigned SC  = 1;
    localparam int unsigned CXW = XW - SC;
    localparam int unsigned CYW = YW - SC;
    localparam int unsigned FCW = 3;

    typedef struct packed {
        logic           draw;
        logic [XW-1:0]  ax;
        logic [YW-1:0]  ay;
        logic [CXW-1:0] cx;
        logic [CYW-1:0] cy;
        logic           hs;
        logic           vs;
        logic           ls;
        logic           fs;
        logic           vb;
        logic [FCW-1:0] fc;
        logic           hs_b;
        logic           vs_b;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    vga_timing_gen_if #(.XW(XW), .YW(YW), .CXW(CXW), .CYW(CYW), .FCW(FCW)) if_a ();
    vga_timing_gen_if #(.XW(XW), .YW(YW), .CXW(XW), .CYW(YW), .FCW(8)) if_b ();
    assign if_b.i_pix_en = if_a.i_pix_en;

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0), .SCALE_LOG2(SC), .FRAME_CNT_W(FCW)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .i_pix_en(if_a.i_pix_en),
        .o_draw_active(if_a.o_draw_active), .o_active_x(if_a.o_active_x),
        .o_active_y(if_a.o_active_y), .o_cell_x(if_a.o_cell_x), .o_cell_y(if_a.o_cell_y),
        .o_h_sync(if_a.o_h_sync), .o_v_sync(if_a.o_v_sync),
        .o_line_start(if_a.o_line_start), .o_frame_start(if_a.o_frame_start),
        .o_vblank(if_a.o_vblank), .o_frame_cnt(if_a.o_frame_cnt)
    );

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .SCALE_LOG2(0), .FRAME_CNT_W(8)
    ) u_dut_pol (
        .clk(clk), .rst_n(rst_n), .i_pix_en(if_b.i_pix_en),
        .o_draw_active(if_b.o_draw_active), .o_active_x(if_b.o_active_x),
        .o_active_y(if_b.o_active_y), .o_cell_x(if_b.o_cell_x), .o_cell_y(if_b.o_cell_y),
        .o_h_sync(if_b.o_h_sync), .o_v_sync(if_b.o_v_sync),
        .o_line_start(if_b.o_line_start), .o_frame_start(if_b.o_frame_start),
        .o_vblank(if_b.o_vblank), .o_frame_cnt(if_b.o_frame_cnt)
    );

    obs_t exp_q[$];
    obs_t last_exp;
    int   mx, my, mfc;
    int   cyc;
    int   total;
    int   bad;

    function automatic obs_t reset_exp();
        obs_t e;
        e      = '0;
        e.hs   = 1'b1;
        e.vs   = 1'b1;
        e.hs_b = 1'b0;
        e.vs_b = 1'b0;
        return e;
    endfunction

    function automatic obs_t sample_outputs();
        obs_t o;
        o.draw = if_a.o_draw_active;
        o.ax   = if_a.o_active_x;
        o.ay   = if_a.o_active_y;
        o.cx   = if_a.o_cell_x;
        o.cy   = if_a.o_cell_y;
        o.hs   = if_a.o_h_sync;
        o.vs   = if_a.o_v_sync;
        o.ls   = if_a.o_line_start;
        o.fs   = if_a.o_frame_start;
        o.vb   = if_a.o_vblank;
        o.fc   = if_a.o_frame_cnt;
        o.hs_b = if_b.o_h_sync;
        o.vs_b = if_b.o_v_sync;
        return o;
    endfunction

    task automatic model_reset();
        mx       = 0;
        my       = 0;
        mfc      = 0;
        last_exp = reset_exp();
    endtask

    // Drive one clock with the given enable, pushing the expected post-edge outputs.
    task automatic drive_cycle(input bit en);
        obs_t e;
        bit   act;
        int   ax, ay;
        if_a.i_pix_en = en;
        if (en) begin
            act    = (mx < HA) && (my < VA);
            ax     = act ? mx : 0;
            ay     = act ? my : 0;
            e.draw = act;
            e.ax   = XW'(ax);
            e.ay   = YW'(ay);
            e.cx   = CXW'(ax / 2);
            e.cy   = CYW'(ay / 2);
            e.hs   = (mx >= HA + HF && mx < HA + HF + HS) ? 1'b0 : 1'b1;
            e.vs   = (my >= VA + VF && my < VA + VF + VS) ? 1'b0 : 1'b1;
            e.hs_b = ~e.hs;
            e.vs_b = ~e.vs;
            e.ls   = (mx == 0);
            e.fs   = (mx == 0) && (my == 0);
            e.vb   = (my >= VA);
            if (mx == HT - 1 && my == VT - 1) mfc = (mfc + 1) % 8;
            e.fc   = FCW'(mfc);
            if (mx == HT - 1) begin
                mx = 0;
                my = (my == VT - 1) ? 0 : my + 1;
            end else begin
                mx = mx + 1;
            end
        end else begin
            e    = last_exp;
            e.ls = 1'b0;
            e.fs = 1'b0;
        end
        last_exp = e;
        exp_q.push_back(e);
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        obs_t o;
        rst_n         = 1'b0;
        if_a.i_pix_en = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        o = sample_outputs();
        total++;
        if (o !== reset_exp()) begin
            bad++;
            $display("FAIL reset_state got=%h want=%h", o, reset_exp());
        end
    endtask

    task automatic test_first_frames();
        obs_t e, o;
        int   last_fs, gaps;
        last_fs = -1;
        gaps    = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * HT * VT + 1) begin
            drive_cycle(1'b1);
            e = exp_q.pop_front();
            o = sample_outputs();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL first_frames cyc=%0d got=%h want=%h", cyc, o, e);
            end
            if (o.fs) begin
                if (last_fs >= 0) begin
                    gaps++;
                    total++;
                    if (cyc - last_fs !== 98) begin
                        bad++;
                        $display("FAIL frame_period got=%0d want=98", cyc - last_fs);
                    end
                end
                last_fs = cyc;
            end
        end
        total++;
        if (gaps !== 2) begin
            bad++;
            $display("FAIL frame_pulse_count got=%0d want=2", gaps);
        end
    endtask

    task automatic test_pix_en_toggle();
        obs_t e, o;
        int   last_fs, gaps;
        last_fs = -1;
        gaps    = 0;
        for (int i = 0; i < 600; i++) begin
            drive_cycle((i % 2) == 0);
            e = exp_q.pop_front();
            o = sample_outputs();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL pix_en_toggle cyc=%0d got=%h want=%h", cyc, o, e);
            end
            if (o.fs) begin
                if (last_fs >= 0) begin
                    gaps++;
                    total++;
                    if (cyc - last_fs !== 196) begin
                        bad++;
                        $display("FAIL half_rate_period got=%0d want=196", cyc - last_fs);
                    end
                end
                last_fs = cyc;
            end
        end
        total++;
        if (gaps < 1) begin
            bad++;
            $display("FAIL half_rate_pulses got=%0d want>=1", gaps);
        end
        if_a.i_pix_en = 1'b1;
    endtask

    task automatic test_frame_cnt_wrap();
        obs_t e, o;
        int   wraps;
        logic [FCW-1:0] prev_fc;
        wraps   = 0;
        prev_fc = if_a.o_frame_cnt;
        repeat (9 * HT * VT) begin
            drive_cycle(1'b1);
            e = exp_q.pop_front();
            o = sample_outputs();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL frame_cnt_run cyc=%0d got=%h want=%h", cyc, o, e);
            end
            if (prev_fc == 3'd7 && o.fc == 3'd0) wraps++;
            prev_fc = o.fc;
        end
        total++;
        if (wraps < 1) begin
            bad++;
            $display("FAIL frame_cnt_wrap got=%0d want>=1", wraps);
        end
    endtask

    task automatic test_mid_reset();
        obs_t e, o;
        int   guard;
        guard = 0;
        while (!(mx == 5 && my == 2) && guard < 200) begin
            drive_cycle(1'b1);
            e = exp_q.pop_front();
            o = sample_outputs();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL pre_reset cyc=%0d got=%h want=%h", cyc, o, e);
            end
            guard++;
        end
        drive_cycle(1'b1);
        e = exp_q.pop_front();
        o = sample_outputs();
        total++;
        if (o !== e) begin
            bad++;
            $display("FAIL at_5_2 got=%h want=%h", o, e);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        o = sample_outputs();
        total++;
        if (o !== reset_exp()) begin
            bad++;
            $display("FAIL async_reset got=%h want=%h", o, reset_exp());
        end
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive_cycle(1'b1);
        e = exp_q.pop_front();
        o = sample_outputs();
        total++;
        if (o !== e || o.fs !== 1'b1 || o.fc !== 3'd0) begin
            bad++;
            $display("FAIL post_reset_first got=%h want=%h", o, e);
        end
        repeat (20) begin
            drive_cycle(1'b1);
            e = exp_q.pop_front();
            o = sample_outputs();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL post_reset_run cyc=%0d got=%h want=%h", cyc, o, e);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        cyc   = 0;
        test_reset();
        test_first_frames();
        test_pix_en_toggle();
        test_frame_cnt_wrap();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 The block SHALL have these parameters:
- H_ACTIVE, default 640: visible pixels per line.
- H_FRONT, default 16: horizontal front porch in pixels.
- H_SYNC, default 96: horizontal sync width in pixels.
- H_BACK, default 48: horizontal back porch in pixels.
- V_ACTIVE, default 480: visible lines per frame.
- V_FRONT, default 10: vertical front porch in lines.
- V_SYNC, default 2: vertical sync width in lines.
- V_BACK, default 33: vertical back porch in lines.
- H_SYNC_POL, default 0: asserted level of o_h_sync.
- V_SYNC_POL, default 0: asserted level of o_v_sync.
- SCALE_LOG2, default 0: log2 of the pixels per cell for cell coordinates.
- FRAME_CNT_W, default 8: width of the frame counter.
REQ-002 The block SHALL have these ports (XW=$clog2(H_ACTIVE), YW=$clog2(V_ACTIVE)):
- clk, input, 1: the single clock.
- rst_n, input, 1: asynchronous, active-low reset.
- i_pix_en, input, 1: pixel-clock enable.
- o_draw_active, output, 1: pixel is inside the visible area.
- o_active_x, output, XW: visible x coordinate, 0 outside the visible area.
- o_active_y, output, YW: visible y coordinate, 0 outside the visible area.
- o_cell_x, output, XW-SCALE_LOG2: o_active_x>>SCALE_LOG2.
- o_cell_y, output, YW-SCALE_LOG2: o_active_y>>SCALE_LOG2.
- o_h_sync, output, 1: horizontal sync.
- o_v_sync, output, 1: vertical sync.
- o_line_start, output, 1: first pixel of a line.
- o_frame_start, output, 1: first pixel of a frame.
- o_vblank, output, 1: current line is outside the visible lines.
- o_frame_cnt, output, FRAME_CNT_W: count of completed frames.

Function
REQ-003 The block SHALL keep internal counters x (0..H_TOTAL-1) and y (0..V_TOTAL-1), where H_TOTAL = sum of the H_* timing parameters and V_TOTAL = sum of the V_* timing parameters.
REQ-004 The counters SHALL advance only on clk edges where i_pix_en=1; when i_pix_en=0 the counters and all level outputs SHALL hold.
REQ-005 On each advance:
- x SHALL wrap to 0 by explicit comparison with H_TOTAL-1; the block SHALL NOT rely on power-of-two overflow.
- When x wraps, y SHALL increment.
- When y is at V_TOTAL-1 and x wraps, y SHALL wrap to 0.
REQ-006 All outputs SHALL be registered.
- On an advancing edge, the output registers SHALL load the decode of the pre-advance (x,y).
- Latency from counter position to output is therefore 1 clk.
REQ-007 o_draw_active SHALL equal (x<H_ACTIVE)&&(y<V_ACTIVE); o_active_x/o_active_y SHALL equal x/y when active, otherwise 0.
REQ-008 o_h_sync SHALL equal H_SYNC_POL while H_ACTIVE+H_FRONT <= x < H_ACTIVE+H_FRONT+H_SYNC, otherwise ~H_SYNC_POL.
REQ-009 o_v_sync SHALL follow the same rule on y with the V_* parameters and V_SYNC_POL.
REQ-010 o_vblank SHALL equal (y>=V_ACTIVE).
REQ-011 o_line_start SHALL be 1 for exactly one clk, on the edge loading x=0.
REQ-012 o_frame_start SHALL be 1 for exactly one clk, on the edge loading (x,y)=(0,0).
REQ-013 Both pulses SHALL clear on the next clk edge regardless of i_pix_en.
REQ-014 o_frame_cnt SHALL increment modulo 2^FRAME_CNT_W on the advance from (H_TOTAL-1,V_TOTAL-1) to (0,0).
REQ-015 The block SHALL reject illegal parameters at elaboration:
- Any timing parameter equal to 0.
- SCALE_LOG2 >= YW.

Reset
REQ-016 rst_n=0 SHALL asynchronously force:
- x=0, y=0, o_frame_cnt=0.
- o_draw_active=0, all coordinates=0.
- o_h_sync=~H_SYNC_POL, o_v_sync=~V_SYNC_POL.
- o_line_start=0, o_frame_start=0, o_vblank=0.
REQ-017 The first advancing edge after reset release SHALL emit position (0,0) with o_line_start=o_frame_start=1.
REQ-018 Reset asserted mid-frame SHALL abandon the frame with no partial-line completion.

Structure
REQ-019 The shared package vga_pkg SHALL hold:
- The default 640x480@60 timing constants.
- A timing struct typedef grouping active/front/sync/back.
REQ-020 Each axis SHALL use one instance of the sub-module vga_axis_counter, parametrised by TOTAL, with inputs i_en and i_step and outputs o_cnt and o_wrap.
- x instance: i_step=1.
- y instance: i_step = x o_wrap.

Verification
REQ-021 Defaults, i_pix_en=1 for 2 frames -> exactly 420000 clks between o_frame_start pulses; o_h_sync low for 96 clks starting 656 clks after o_line_start; o_frame_cnt 0->1->2.
REQ-022 Small parameters 8/2/2/2 by 4/1/1/1 -> H_TOTAL=14, V_TOTAL=7; x sequence 0..13,0 with no value 14/15; y wraps 6->0; o_frame_start period 98 clks.
REQ-023 i_pix_en toggling 1,0,1,0 -> counters and outputs hold on en=0 cycles; pulses last 1 clk and frame period doubles to 840000 clks.
REQ-024 H_SYNC_POL=1, V_SYNC_POL=1 -> syncs idle 0 from reset and asserted 1 in the sync windows.
REQ-025 SCALE_LOG2=3 at (x,y)=(637,479) -> o_cell_x=79, o_cell_y=59; outside the visible area all coordinates read 0.
REQ-026 rst_n pulsed low at (300,200) -> all outputs at reset values within the same cycle; after release the first edge emits (0,0) with o_frame_start=1 and o_frame_cnt=0.
